sccb_master: RTL and testbench
==============================

SCCB_MASTER -- requirements
Module: sccb_master

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SCCB_FREQ, default 100_000, SIOC bit rate in Hz; QTR = CLK_FREQ/(4*SCCB_FREQ), which SHALL be >= 1.
REQ-003 Parameter DEV_ID, default 8'h42, camera write ID sent as the first phase.
REQ-004 clk  input  1  single clock, rising-edge active.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sccb_start  input  1  request one 3-phase write; sampled only in IDLE.
REQ-007 sccb_addr  input  8  register address; latched on an accepted start.
REQ-008 sccb_data  input  8  register value; latched on an accepted start.
REQ-009 sccb_done  output  1  one-cycle pulse marking transaction completion.
REQ-010 busy  output  1  high from the cycle after acceptance through the done cycle.
REQ-011 sioc  output  1  SCCB clock, push-pull.
REQ-012 siod_out  output  1  SCCB data value when driven.
REQ-013 siod_oe  output  1  1 = drive siod_out; 0 = release (pad pulled high).

Function
REQ-014 States SHALL be IDLE, START, BITS, STOP, DONE; all non-IDLE timing SHALL advance on a quarter-tick every QTR clocks.
REQ-015 IDLE: sioc=1, siod_oe=0; sccb_start=1 -> latch addr/data, load shift {DEV_ID,addr,data}, go to START on the next cycle.
REQ-016 START: quarter 0 siod_oe=1, siod_out=0, sioc=1; quarter 1 sioc=0; then go to BITS.
REQ-017 BITS: 27 bit slots (3 phases x 9 bits), MSB first; each slot is 4 quarters: q0-q1 sioc=0, q2-q3 sioc=1; siod_out changes only at q0.
REQ-018 Slots 9, 18, and 27 (don't-care bits) SHALL have siod_oe=0; all other slots siod_oe=1.
REQ-019 STOP: q0 sioc=0, siod_oe=1, siod_out=0; q1 sioc=1; q2 siod_oe=0; then go to DONE.
REQ-020 DONE: sccb_done=1 for exactly one cycle, then go to IDLE.
REQ-021 Latency: taking the accepting cycle as 0, sccb_done SHALL be high in cycle 113*QTR+1.
REQ-022 sccb_start while busy SHALL be ignored and not queued; sccb_start in the cycle after DONE SHALL be accepted.
REQ-023 Input changes on addr/data after acceptance SHALL NOT affect the transaction in flight.
REQ-024 The bit counter SHALL be 5 bits and the quarter counter 2 bits; the divider SHALL be ceil(log2(QTR)) bits wide and SHALL wrap at QTR-1.
REQ-025 Acknowledge from the slave SHALL NOT be checked.

Reset
REQ-026 rst_n low SHALL force IDLE immediately, with sioc=1, siod_oe=0, siod_out=1, sccb_done=0, busy=0, and clear all counters and the shift register.
REQ-027 Reset mid-transaction SHALL abort without a done pulse; after release, the next start SHALL begin a full fresh transaction.

Structure
REQ-028 Package sccb_pkg SHALL hold the state enum, DEV_ID default, BITS_PER_XFER=27, and the don't-care slot indices.
REQ-029 The quarter-tick divider SHALL be sub-module sccb_tick_gen (en, tick output); it SHALL be cleared on IDLE entry.

Verification
REQ-030 Benches SHALL use CLK_FREQ=800 and SCCB_FREQ=100, giving QTR=2.
REQ-031 Single write addr=12 data=80 -> SIOD sampled on SIOC rising edges = 42,Z,12,Z,80,Z bitwise; start/stop edges correct; sccb_done in cycle 227.
REQ-032 sccb_start held high continuously -> exactly one transaction per 228 cycles; the done count equals the number of accepted transactions.
REQ-033 addr/data changed to FF/FF in the cycle after acceptance -> bus still carries 12/80.
REQ-034 rst_n pulsed low at cycle 100 -> sioc=1 and siod_oe=0 the same cycle, no sccb_done; the next write addr=3A data=04 completes correctly.
REQ-035 Twenty back-to-back writes driven by a config sequencer model -> all 20 addr/data pairs decoded by a bus monitor in order.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB (camera register) write master.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam logic [7:0] DEV_ID_DEFAULT = 8'h42;
  localparam int         BITS_PER_XFER  = 27;

  // Zero-based slot indices of the three don't-care (ack) bits: slots 9, 18, 27 counted from one.
  localparam logic [4:0] DC_SLOT_0 = 5'd8;
  localparam logic [4:0] DC_SLOT_1 = 5'd17;
  localparam logic [4:0] DC_SLOT_2 = 5'd26;
  localparam logic [4:0] LAST_SLOT = 5'(BITS_PER_XFER - 1);

  function automatic logic is_dc_slot(input logic [4:0] slot);
    return (slot == DC_SLOT_0) || (slot == DC_SLOT_1) || (slot == DC_SLOT_2);
  endfunction

endpackage

// File: rtl/sccb_master_if.sv
// Request/response and SCCB pad signals between a register sequencer and sccb_master.
interface sccb_master_if;
  logic       sccb_start;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_data;
  logic       sccb_done;
  logic       busy;
  logic       sioc;
  logic       siod_out;
  logic       siod_oe;

  modport master (
    input  sccb_start, sccb_addr, sccb_data,
    output sccb_done, busy, sioc, siod_out, siod_oe
  );

  modport slave (
    output sccb_start, sccb_addr, sccb_data,
    input  sccb_done, busy, sioc, siod_out, siod_oe
  );
endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick divider: pulses tick every QTR enabled clocks, held at zero while disabled.
module sccb_tick_gen #(
  parameter int QTR = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int         W    = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [W-1:0] LAST = W'(QTR - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/sccb_master.sv
// SCCB 3-phase write master: START, {DEV_ID, addr, data} with unchecked ack slots, STOP, done pulse.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int         CLK_FREQ  = 100_000_000,
  parameter int         SCCB_FREQ = 100_000,
  parameter logic [7:0] DEV_ID    = DEV_ID_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  sccb_master_if.master bus
);

  localparam int QTR = CLK_FREQ / (4 * SCCB_FREQ);

  generate
    if (QTR < 1) begin : g_qtr_check
      $error("sccb_master: CLK_FREQ must be at least 4*SCCB_FREQ");
    end
  endgenerate

  state_t                   state_q, state_d;
  logic [1:0]               qtr_q, qtr_d;
  logic [4:0]               bit_q, bit_d;
  logic [BITS_PER_XFER-1:0] shift_q, shift_d;

  logic tick_en;
  logic tick;
  logic sioc_c, siod_out_c, siod_oe_c, done_c;

  // Divider only runs while the bus is being timed, so it restarts cleanly from IDLE.
  assign tick_en = (state_q == ST_START) || (state_q == ST_BITS) || (state_q == ST_STOP);

  sccb_tick_gen #(.QTR(QTR)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      qtr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        qtr_d = '0;
        bit_d = '0;
        if (bus.sccb_start) begin
          // Ack slots are padded with 1 so one shift per slot keeps the phases aligned.
          shift_d = {DEV_ID, 1'b1, bus.sccb_addr, 1'b1, bus.sccb_data, 1'b1};
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (qtr_q == 2'd1) begin
            qtr_d   = '0;
            state_d = ST_BITS;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      ST_BITS: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            shift_d = {shift_q[BITS_PER_XFER-2:0], 1'b1};
            if (bit_q == LAST_SLOT) begin
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (qtr_q == 2'd2) begin
            qtr_d   = '0;
            state_d = ST_DONE;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        qtr_d   = '0;
        bit_d   = '0;
        shift_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    sioc_c     = 1'b1;
    siod_oe_c  = 1'b0;
    siod_out_c = 1'b1;
    done_c     = 1'b0;
    case (state_q)
      ST_START: begin
        siod_oe_c  = 1'b1;
        siod_out_c = 1'b0;
        sioc_c     = (qtr_q == 2'd0);
      end
      ST_BITS: begin
        sioc_c     = qtr_q[1];
        siod_oe_c  = !is_dc_slot(bit_q);
        siod_out_c = shift_q[BITS_PER_XFER-1];
      end
      ST_STOP: begin
        sioc_c     = (qtr_q != 2'd0);
        siod_oe_c  = (qtr_q != 2'd2);
        siod_out_c = (qtr_q == 2'd2);
      end
      ST_DONE: begin
        done_c = 1'b1;
      end
      default: begin
        sioc_c = 1'b1;
      end
    endcase
  end

  assign bus.sioc      = sioc_c;
  assign bus.siod_oe   = siod_oe_c;
  assign bus.siod_out  = siod_out_c;
  assign bus.sccb_done = done_c;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master: a pad-level monitor decodes frames from SIOC/SIOD edges.
module tb_sccb_master;

  localparam int CLK_FREQ  = 800;
  localparam int SCCB_FREQ = 100;
  localparam int QTR       = 2;
  localparam int DONE_CYC  = 113 * QTR + 1;
  localparam int PERIOD    = DONE_CYC + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sccb_master_if bus ();

  sccb_master #(
    .CLK_FREQ  (CLK_FREQ),
    .SCCB_FREQ (SCCB_FREQ),
    .DEV_ID    (8'h42)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] id;
    logic [7:0] addr;
    logic [7:0] data;
    logic       oe_ok;
  } frame_t;

  frame_t      frames[$];
  int          starts    = 0;
  int          bad_stops = 0;
  int          bit_cnt   = 99;
  logic        sioc_p    = 1'b1;
  logic        line_p    = 1'b1;
  logic        line;
  logic [26:0] bits_r;
  logic [26:0] oe_r;
  localparam logic [26:0] OE_PATTERN = 27'b111111110_111111110_111111110;

  // Bus monitor: the pad line reads 1 when released; bits are taken on SIOC rising edges.
  always @(negedge clk) begin
    frame_t f;
    line = bus.siod_oe ? bus.siod_out : 1'b1;
    if (sioc_p && bus.sioc && line_p && !line) begin
      bit_cnt = 0;
      starts++;
    end else if (!sioc_p && bus.sioc) begin
      if (bit_cnt < 27) begin
        bits_r[26-bit_cnt] = line;
        oe_r[26-bit_cnt]   = bus.siod_oe;
      end
      if (bit_cnt < 99) bit_cnt++;
    end else if (sioc_p && bus.sioc && !line_p && line) begin
      if (bit_cnt == 28) begin
        f.id    = bits_r[26:19];
        f.addr  = bits_r[17:10];
        f.data  = bits_r[8:1];
        f.oe_ok = (oe_r == OE_PATTERN);
        frames.push_back(f);
      end else begin
        bad_stops++;
      end
      bit_cnt = 99;
    end
    sioc_p = bus.sioc;
    line_p = line;
  end

  logic [7:0] seq_addr [20] = '{8'h12, 8'h11, 8'h3A, 8'h40, 8'h8C, 8'h17, 8'h18, 8'h32, 8'h19, 8'h1A,
                                8'h03, 8'h0C, 8'h3E, 8'h70, 8'h71, 8'h72, 8'h73, 8'hA2, 8'h15, 8'h7A};
  logic [7:0] seq_data [20] = '{8'h80, 8'h01, 8'h04, 8'hD0, 8'h00, 8'h16, 8'h04, 8'h24, 8'h02, 8'h7A,
                                8'h0A, 8'h00, 8'h00, 8'h3A, 8'h35, 8'h11, 8'hF0, 8'h02, 8'h00, 8'h20};

  // Issues one request and returns once it has been accepted (now inside cycle 1).
  task automatic issue(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.sccb_start = 1'b1;
    bus.sccb_addr  = a;
    bus.sccb_data  = d;
    @(posedge clk);
    #1;
    bus.sccb_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit busy_ok);
    cyc     = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.sccb_done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.sioc !== 1'b1)      begin fails++; $display("FAIL reset_sioc: got %b want 1", bus.sioc); end
    tests++; if (bus.siod_oe !== 1'b0)   begin fails++; $display("FAIL reset_oe: got %b want 0", bus.siod_oe); end
    tests++; if (bus.siod_out !== 1'b1)  begin fails++; $display("FAIL reset_out: got %b want 1", bus.siod_out); end
    tests++; if (bus.sccb_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.sccb_done); end
    tests++; if (bus.busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (bus.busy !== 1'b0)      begin fails++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    $display("[TB] reset: outputs idle");
  endtask

  task automatic test_single_write();
    int cyc;
    bit bok;
    frames.delete();
    starts = 0;
    issue(8'h12, 8'h80);
    wait_done(400, cyc, bok);
    tests++; if (cyc != DONE_CYC) begin fails++; $display("FAIL single_latency: got %0d want %0d", cyc, DONE_CYC); end
    tests++; if (!bok)            begin fails++; $display("FAIL single_busy: busy dropped before done"); end
    @(negedge clk);
    tests++; if (bus.sccb_done !== 1'b0 || bus.busy !== 1'b0)
      begin fails++; $display("FAIL single_after_done: done=%b busy=%b want 0/0", bus.sccb_done, bus.busy); end
    tests++; if (starts != 1 || frames.size() != 1)
      begin fails++; $display("FAIL single_frames: starts=%0d frames=%0d want 1/1", starts, frames.size()); end
    if (frames.size() > 0) begin
      tests++; if (frames[0].id !== 8'h42 || frames[0].addr !== 8'h12 || frames[0].data !== 8'h80)
        begin fails++; $display("FAIL single_bytes: got %h/%h/%h want 42/12/80", frames[0].id, frames[0].addr, frames[0].data); end
      tests++; if (frames[0].oe_ok !== 1'b1)
        begin fails++; $display("FAIL single_dc_slots: got oe %b want %b", oe_r, OE_PATTERN); end
    end
    $display("[TB] single write 12/80: done cycle %0d, frames %0d", cyc, frames.size());
  endtask

  task automatic test_start_held();
    int n_done = 0;
    int d_cyc [3] = '{0, 0, 0};
    frames.delete();
    @(posedge clk);
    #1;
    bus.sccb_start = 1'b1;
    bus.sccb_addr  = 8'h5A;
    bus.sccb_data  = 8'hC3;
    @(posedge clk);
    for (int k = 1; k <= 3 * PERIOD; k++) begin
      @(negedge clk);
      if (bus.sccb_done === 1'b1) begin
        if (n_done < 3) d_cyc[n_done] = k;
        n_done++;
      end
      if (k == 3 * PERIOD) bus.sccb_start = 1'b0;
    end
    tests++; if (n_done != 3) begin fails++; $display("FAIL held_done_count: got %0d want 3", n_done); end
    tests++; if (d_cyc[0] != DONE_CYC || d_cyc[1] != DONE_CYC + PERIOD || d_cyc[2] != DONE_CYC + 2 * PERIOD)
      begin fails++; $display("FAIL held_spacing: got %0d,%0d,%0d want 227,455,683", d_cyc[0], d_cyc[1], d_cyc[2]); end
    tests++; if (frames.size() != n_done)
      begin fails++; $display("FAIL held_frames: got %0d frames want %0d", frames.size(), n_done); end
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL held_no_queue: busy=%b want 0", bus.busy); end
    $display("[TB] start held: %0d dones, %0d frames", n_done, frames.size());
  endtask

  task automatic test_input_change();
    int cyc;
    bit bok;
    frames.delete();
    issue(8'h12, 8'h80);
    bus.sccb_addr = 8'hFF;
    bus.sccb_data = 8'hFF;
    wait_done(400, cyc, bok);
    tests++; if (cyc != DONE_CYC) begin fails++; $display("FAIL change_latency: got %0d want %0d", cyc, DONE_CYC); end
    tests++; if (frames.size() != 1 || frames[0].addr !== 8'h12 || frames[0].data !== 8'h80)
      begin fails++; $display("FAIL change_bytes: frames=%0d want one frame carrying 12/80", frames.size()); end
    $display("[TB] input change after accept: frames %0d", frames.size());
  endtask

  task automatic test_reset_mid();
    int cyc;
    int n_done = 0;
    bit bok;
    frames.delete();
    issue(8'h11, 8'h22);
    repeat (99) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus.sioc !== 1'b1 || bus.siod_oe !== 1'b0 || bus.busy !== 1'b0)
      begin fails++; $display("FAIL midreset_outputs: sioc=%b oe=%b busy=%b want 1/0/0", bus.sioc, bus.siod_oe, bus.busy); end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 4) rst_n = 1'b1;
      if (bus.sccb_done === 1'b1) n_done++;
    end
    tests++; if (n_done != 0 || frames.size() != 0)
      begin fails++; $display("FAIL midreset_abort: dones=%0d frames=%0d want 0/0", n_done, frames.size()); end
    issue(8'h3A, 8'h04);
    wait_done(400, cyc, bok);
    tests++; if (cyc != DONE_CYC) begin fails++; $display("FAIL midreset_latency: got %0d want %0d", cyc, DONE_CYC); end
    tests++; if (frames.size() != 1 || frames[0].id !== 8'h42 || frames[0].addr !== 8'h3A
                 || frames[0].data !== 8'h04 || frames[0].oe_ok !== 1'b1)
      begin fails++; $display("FAIL midreset_next: frames=%0d want one clean 42/3A/04 frame", frames.size()); end
    $display("[TB] mid-transaction reset: aborted, next write frames %0d", frames.size());
  endtask

  task automatic test_back_to_back();
    int idx    = 1;
    int n_done = 0;
    int last_k = -1;
    frames.delete();
    @(posedge clk);
    #1;
    bus.sccb_start = 1'b1;
    bus.sccb_addr  = seq_addr[0];
    bus.sccb_data  = seq_data[0];
    @(posedge clk);
    for (int k = 1; k <= 20 * PERIOD + 50; k++) begin
      @(negedge clk);
      if (bus.sccb_done === 1'b1) begin
        n_done++;
        last_k = k;
        if (idx < 20) begin
          bus.sccb_addr = seq_addr[idx];
          bus.sccb_data = seq_data[idx];
          idx++;
        end else begin
          bus.sccb_start = 1'b0;
        end
      end
      if (n_done == 20) break;
    end
    bus.sccb_start = 1'b0;
    tests++; if (n_done != 20 || last_k != 20 * PERIOD - 1)
      begin fails++; $display("FAIL b2b_done: count=%0d last=%0d want 20/%0d", n_done, last_k, 20 * PERIOD - 1); end
    tests++; if (frames.size() != 20) begin fails++; $display("FAIL b2b_frames: got %0d want 20", frames.size()); end
    for (int i = 0; i < 20 && i < frames.size(); i++) begin
      tests++;
      if (frames[i].id !== 8'h42 || frames[i].addr !== seq_addr[i] || frames[i].data !== seq_data[i])
        begin fails++; $display("FAIL b2b_pair%0d: got %h/%h/%h want 42/%h/%h", i, frames[i].id,
                                frames[i].addr, frames[i].data, seq_addr[i], seq_data[i]); end
    end
    $display("[TB] back-to-back: %0d dones, %0d frames", n_done, frames.size());
  endtask

  initial begin
    bus.sccb_start = 1'b0;
    bus.sccb_addr  = 8'h00;
    bus.sccb_data  = 8'h00;
    test_reset();
    test_single_write();
    test_start_held();
    test_input_change();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
